mips_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation MIPS core. Replaces the core's combinational PC/next-address logic with a registered PC, a credit-limited pipelined instruction-memory request/response port and a DEPTH-entry instruction buffer. It computes branch, jump and register redirect targets internally and coordinates an orderly halt. It sits between instruction memory and the decode/control stage.

---
 rtl/mips_pkg.sv | 6 +
 rtl/mips_fetch_unit_if.sv | 23 ++
 rtl/mips_inst_fifo.sv | 39 +++
 rtl/mips_fetch_unit.sv | 85 ++++++++
 tb/tb_mips_fetch_unit.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS fetch front end.
package mips_pkg;
    localparam int INST_W = 32;
    typedef enum logic [1:0] {NONE, BRANCH, JUMP, REG} redirect_kind_t;
    typedef enum logic [1:0] {RUN, HALTING, HALTED} fetch_state_t;
endpackage

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: imem port, decode hand-off, redirect and halt signals of the fetch unit.
interface mips_fetch_unit_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic inst_valid, inst_ready, halt_req, halted;
    logic [ADDR_W-1:0] imem_req_addr, inst_pc, redirect_base_pc, redirect_reg;
    logic [INST_W-1:0] imem_rsp_data, inst_out;
    logic [25:0] redirect_imm;
    redirect_kind_t redirect_kind;
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc, halted,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_kind, redirect_base_pc, redirect_imm, redirect_reg, halt_req
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc, halted,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_kind, redirect_base_pc, redirect_imm, redirect_reg, halt_req
    );
endinterface

// File: rtl/mips_inst_fifo.sv
// mips_inst_fifo: synchronous FIFO with single-cycle flush and occupancy count.
module mips_inst_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             data_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0] cnt_q;
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push_i ? wr_q + AW'(1) : wr_q;
            rd_q  <= pop_i ? rd_q + AW'(1) : rd_q;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: registered-PC fetch front end with a credit-limited imem port,
// instruction buffer, internal redirect target arithmetic and orderly halt.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst_b,
    mips_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = CW + 4;
    localparam int FW = INST_W + ADDR_W;

    fetch_state_t state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, p4, target;
    logic [CW-1:0] out_q, out_d, count;
    logic [DW-1:0] drop_q, drop_d;
    logic [FW-1:0] head, shown, last_q;
    logic redir, req_fire, rsp_keep, pop, empty;

    assign redir    = bus.redirect_kind != NONE && state_q != HALTED;
    assign empty    = count == '0;
    assign pop      = !empty && bus.inst_ready;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep = bus.imem_rsp_valid && drop_q == '0 && !redir;
    assign p4       = bus.redirect_base_pc + ADDR_W'(4);
    assign shown    = empty ? last_q : head;

    always_comb begin
        target   = bus.redirect_kind == BRANCH ?
                       p4 + {{(ADDR_W-18){bus.redirect_imm[15]}}, bus.redirect_imm[15:0], 2'b00} :
                   bus.redirect_kind == JUMP ? {p4[ADDR_W-1:28], bus.redirect_imm, 2'b00} :
                   bus.redirect_reg & ~ADDR_W'(3);
        // In-flight requests at a redirect become drops; a response landing this cycle consumes one.
        drop_d   = redir ? drop_q + DW'(out_q) - DW'(bus.imem_rsp_valid) :
                           drop_q - DW'(bus.imem_rsp_valid && drop_q != '0);
        out_d    = redir ? '0 : out_q + CW'(req_fire) - CW'(rsp_keep);
        pc_d     = redir ? target : req_fire ? pc_q + ADDR_W'(4) : pc_q;
        // Responses return in order, so the next kept one belongs to this PC.
        rsp_pc_d = redir ? target : rsp_keep ? rsp_pc_q + ADDR_W'(4) : rsp_pc_q;
        state_d  = state_q == RUN ? (bus.halt_req ? HALTING : RUN) :
                   state_q == HALTING ? (out_q == '0 && empty ? HALTED : HALTING) : HALTED;
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            last_q   <= shown;
        end
    end

    mips_inst_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .push_i  (rsp_keep),
        .pop_i   (pop),
        .flush_i (redir),
        .data_i  ({bus.imem_rsp_data, rsp_pc_q}),
        .data_o  (head),
        .count_o (count)
    );

    assign bus.imem_req_valid = !rst_b && state_q == RUN && bus.redirect_kind == NONE &&
                                ({1'b0, out_q} + {1'b0, count}) < (CW+1)'(DEPTH);
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = !empty;
    assign bus.inst_out       = shown[FW-1:ADDR_W];
    assign bus.inst_pc        = shown[ADDR_W-1:0];
    assign bus.halted         = state_q == HALTED;
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed bench with an in-order imem model and an expected-PC scoreboard.
module tb_mips_fetch_unit;
    import mips_pkg::*;
    localparam int AW = 32;

    logic clk = 0, rst_b = 1, mem_stall = 0;
    int checks = 0, failures = 0, req_cnt = 0;
    logic [AW-1:0] pend[$], exp_q[$];

    mips_fetch_unit_if #(.ADDR_W(AW)) bus ();
    mips_fetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(32'h0)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(logic [AW-1:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // In-order memory, one-cycle latency unless stalled.
    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            pend.delete();
            req_cnt <= 0;
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data <= '0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend.push_back(bus.imem_req_addr);
                req_cnt <= req_cnt + 1;
            end
            bus.imem_rsp_valid <= !mem_stall && pend.size() > 0;
            if (!mem_stall && pend.size() > 0) bus.imem_rsp_data <= mem_f(pend.pop_front());
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(string tag);
        logic [AW-1:0] e;
        for (int i = 0; i < 40 && !bus.inst_valid; i++) @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
        e = 32'hDEAD_BEEF;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, "_pc"}, bus.inst_pc, e);
        chk({tag, "_inst"}, bus.inst_out, mem_f(e));
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
    endtask

    task automatic redirect(string tag, redirect_kind_t k, logic [AW-1:0] base, logic [25:0] imm,
                            logic [AW-1:0] rreg, logic [AW-1:0] tgt, int n);
        bus.redirect_kind = k;
        bus.redirect_base_pc = base;
        bus.redirect_imm = imm;
        bus.redirect_reg = rreg;
        #1 chk({tag, "_noreq"}, 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        bus.redirect_kind = NONE;
        #1 chk({tag, "_flushed"}, 32'(bus.inst_valid), 32'd0);
        chk({tag, "_req"}, 32'(bus.imem_req_valid), 32'd1);
        chk({tag, "_target"}, bus.imem_req_addr, tgt);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(tgt + 32'(4 * i));
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b0;
        bus.redirect_kind = NONE;
        bus.redirect_base_pc = '0;
        bus.redirect_imm = '0;
        bus.redirect_reg = '0;
        bus.halt_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst_out", bus.inst_out, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        rst_b = 1'b0;
        #1 chk("rel_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("rel_req_addr", bus.imem_req_addr, 32'h0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        @(negedge clk);
        chk("seq_addr4", bus.imem_req_addr, 32'h4);
        chk("seq_not_yet", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        chk("seq_addr8", bus.imem_req_addr, 32'h8);
        chk("first_valid", 32'(bus.inst_valid), 32'd1);
        chk("first_pc", bus.inst_pc, 32'h0);
        repeat (6) @(negedge clk);
        chk("full_stall", 32'(bus.imem_req_valid), 32'd0);
        chk("full_req_cnt", 32'(req_cnt), 32'd4);
        pop_chk("p0");
        chk("resume_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("resume_addr", bus.imem_req_addr, 32'h10);
        repeat (5) pop_chk("run");
        // Branch with responses held back so in-flight ones must be dropped.
        mem_stall = 1'b1;
        repeat (6) @(negedge clk);
        redirect("br", BRANCH, 32'h100, 26'h000FFFE, '0, 32'h0FC, 3);
        mem_stall = 1'b0;
        repeat (3) pop_chk("br");
        redirect("jmp", JUMP, 32'h3000_0010, 26'h0000040, '0, 32'h3000_0100, 3);
        repeat (3) pop_chk("jmp");
        redirect("jr", REG, '0, '0, 32'h203, 32'h200, 9);
        repeat (3) pop_chk("jr");
        // Halt with two requests outstanding and one instruction buffered.
        repeat (8) @(negedge clk);
        chk("hl_full", 32'(bus.imem_req_valid), 32'd0);
        mem_stall = 1'b1;
        pop_chk("hl");
        pop_chk("hl");
        bus.halt_req = 1'b1;
        pop_chk("hl");
        chk("hl_noreq", 32'(bus.imem_req_valid), 32'd0);
        chk("hl_pc", bus.imem_req_addr, 32'h224);
        chk("hl_not_halted", 32'(bus.halted), 32'd0);
        mem_stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("hl_drain_noreq", 32'(bus.imem_req_valid), 32'd0);
        pop_chk("hl");
        pop_chk("hl");
        chk("hl_before_last", 32'(bus.halted), 32'd0);
        pop_chk("hl");
        @(negedge clk);
        chk("halted", 32'(bus.halted), 32'd1);
        chk("halted_empty", 32'(bus.inst_valid), 32'd0);
        bus.redirect_kind = JUMP;
        bus.redirect_base_pc = 32'h1000;
        #1 chk("hd_noreq", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        bus.redirect_kind = NONE;
        #1 chk("hd_sticky", 32'(bus.halted), 32'd1);
        chk("hd_pc_kept", bus.imem_req_addr, 32'h224);
        @(negedge clk);
        bus.halt_req = 1'b0;
        #2 rst_b = 1'b1;
        #1 chk("hd_rst_halted", 32'(bus.halted), 32'd0);
        chk("hd_rst_addr", bus.imem_req_addr, 32'h0);
        // Free-running burst, then asynchronous reset mid-cycle.
        @(negedge clk);
        rst_b = 1'b0;
        bus.inst_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("burst_valid", 32'(bus.inst_valid), 32'd1);
        chk("burst_pc", bus.inst_pc, 32'h10);
        #2 rst_b = 1'b1;
        #1 chk("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("mid_rst_addr", bus.imem_req_addr, 32'h0);
        chk("mid_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("mid_rst_inst_out", bus.inst_out, 32'h0);
        chk("mid_rst_inst_pc", bus.inst_pc, 32'h0);
        chk("mid_rst_halted", 32'(bus.halted), 32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        bus.inst_ready = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
